// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// timer control bit positions and the compare register's reset value.
package dmem_pkg;

    localparam logic [7:0] OFF_CYCLE = 8'h00;
    localparam logic [7:0] OFF_GPIO  = 8'h04;
    localparam logic [7:0] OFF_TCNT  = 8'h08;
    localparam logic [7:0] OFF_TCMP  = 8'h0C;
    localparam logic [7:0] OFF_TCTRL = 8'h10;

    localparam int TCTRL_EN     = 0;
    localparam int TCTRL_AUTO   = 1;
    localparam int TCTRL_MATCH  = 2;
    localparam int TCTRL_IRQ_EN = 3;

    localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

    function automatic logic [31:0] tctrl_pack(input logic en, input logic auto_rl,
                                               input logic match, input logic irq_en);
        logic [31:0] v;
        v = 32'h0000_0000;
        v[TCTRL_EN]     = en;
        v[TCTRL_AUTO]   = auto_rl;
        v[TCTRL_MATCH]  = match;
        v[TCTRL_IRQ_EN] = irq_en;
        return v;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Compare timer for the MMIO page: TCNT/TCMP/TCTRL registers, match and
// auto-reload stepping, and the level interrupt output.
module mmio_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tcnt_we_i,
    input  logic        tcmp_we_i,
    input  logic        tctrl_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] tcnt_o,
    output logic [31:0] tcmp_o,
    output logic [31:0] tctrl_o,
    output logic        irq_o
);

    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] tcmp_q, tcmp_d;
    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        match_q, match_d;
    logic        irq_en_q, irq_en_d;
    logic        hit_s;

    assign hit_s = en_q && (tcnt_q == tcmp_q);

    // Next-state: CPU store to TCNT overrides the step; a match set overrides a W1C clear.
    always_comb begin
        tcnt_d   = tcnt_q;
        tcmp_d   = tcmp_q;
        en_d     = en_q;
        auto_d   = auto_q;
        match_d  = match_q;
        irq_en_d = irq_en_q;

        if (en_q) begin
            if (hit_s && auto_q) begin
                tcnt_d = 32'h0000_0000;
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end else begin
            tcnt_d = tcnt_q;
        end

        if (tcnt_we_i) begin
            tcnt_d = wdata_i;
        end else begin
            tcnt_d = tcnt_d;
        end

        if (tcmp_we_i) begin
            tcmp_d = wdata_i;
        end else begin
            tcmp_d = tcmp_q;
        end

        if (tctrl_we_i) begin
            en_d     = wdata_i[TCTRL_EN];
            auto_d   = wdata_i[TCTRL_AUTO];
            irq_en_d = wdata_i[TCTRL_IRQ_EN];
            if (wdata_i[TCTRL_MATCH]) begin
                match_d = 1'b0;
            end else begin
                match_d = match_q;
            end
        end else begin
            match_d = match_q;
        end

        if (hit_s) begin
            match_d = 1'b1;
        end else begin
            match_d = match_d;
        end
    end

    // Timer register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q   <= 32'h0000_0000;
            tcmp_q   <= TCMP_RESET;
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            match_q  <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            tcnt_q   <= tcnt_d;
            tcmp_q   <= tcmp_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            match_q  <= match_d;
            irq_en_q <= irq_en_d;
        end
    end

    assign tcnt_o  = tcnt_q;
    assign tcmp_o  = tcmp_q;
    assign tctrl_o = tctrl_pack(en_q, auto_q, match_q, irq_en_q);
    assign irq_o   = match_q & irq_en_q;

endmodule

// File: rtl/dmem_mmio.sv
// CPU data-memory responder: word RAM, MMIO page (CYCLE, GPIO, optional timer).
// Define DMEM_MMIO_TIMER_EN to include the compare timer at offsets 0x08-0x10.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  mem_sel,
    output logic [31:0] mem_data,
    output logic [31:0] gpio_out,
    output logic        timer_irq
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   ram_q [DEPTH];
    logic [31:0]   cycle_q, cycle_d;
    logic [31:0]   gpio_q, gpio_d;
    logic          ram_hit_s;
    logic          mmio_hit_s;
    logic [7:0]    off_s;
    logic [AW-1:0] ram_idx_s;
    logic          ram_we_s;
    logic          gpio_we_s;
    logic [31:0]   rdata_s;
    logic [1:0]    unused_lsb_s;

    assign ram_hit_s    = (addr[31:AW+2] == {(30-AW){1'b0}});
    assign mmio_hit_s   = (addr[31:8] == MMIO_BASE[31:8]);
    assign off_s        = {addr[7:2], 2'b00};
    assign ram_idx_s    = addr[AW+1:2];
    assign unused_lsb_s = addr[1:0];

    assign ram_we_s  = MemWrite & ram_hit_s;
    assign gpio_we_s = MemWrite & mmio_hit_s & (off_s == OFF_GPIO);

`ifdef DMEM_MMIO_TIMER_EN
    logic [31:0] tcnt_s, tcmp_s, tctrl_s;

    mmio_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .tcnt_we_i  (MemWrite & mmio_hit_s & (off_s == OFF_TCNT)),
        .tcmp_we_i  (MemWrite & mmio_hit_s & (off_s == OFF_TCMP)),
        .tctrl_we_i (MemWrite & mmio_hit_s & (off_s == OFF_TCTRL)),
        .wdata_i    (writedata),
        .tcnt_o     (tcnt_s),
        .tcmp_o     (tcmp_s),
        .tctrl_o    (tctrl_s),
        .irq_o      (timer_irq)
    );
`else
    assign timer_irq = 1'b0;
`endif

    // Word RAM; stores commit on the edge, so loads always see pre-edge contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram_q[i] <= 32'h0000_0000;
            end
        end else if (ram_we_s) begin
            ram_q[ram_idx_s] <= writedata;
        end
    end

    // CYCLE is read-only and free-running; GPIO takes CPU stores.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (gpio_we_s) begin
            gpio_d = writedata;
        end else begin
            gpio_d = gpio_q;
        end
    end

    // CYCLE and GPIO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= 32'h0000_0000;
            gpio_q  <= 32'h0000_0000;
        end else begin
            cycle_q <= cycle_d;
            gpio_q  <= gpio_d;
        end
    end

    // Load data mux: RAM, MMIO register, or zero for anything unmapped.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (ram_hit_s) begin
            rdata_s = ram_q[ram_idx_s];
        end else if (mmio_hit_s) begin
            case (off_s)
                OFF_CYCLE: rdata_s = cycle_q;
                OFF_GPIO:  rdata_s = gpio_q;
`ifdef DMEM_MMIO_TIMER_EN
                OFF_TCNT:  rdata_s = tcnt_s;
                OFF_TCMP:  rdata_s = tcmp_s;
                OFF_TCTRL: rdata_s = tctrl_s;
`endif
                default:   rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign readdata = rdata_s;
    assign mem_data = ram_q[mem_sel[AW-1:0]];
    assign gpio_out = gpio_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: expected load data is queued as each bus
// operation is driven and compared when the combinational readdata settles.
module tb_dmem_mmio;

    localparam logic [31:0] A_CYCLE = 32'hFFFF_0000;
    localparam logic [31:0] A_GPIO  = 32'hFFFF_0004;
    localparam logic [31:0] A_TCNT  = 32'hFFFF_0008;
    localparam logic [31:0] A_TCMP  = 32'hFFFF_000C;
    localparam logic [31:0] A_TCTRL = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  mem_sel;
    logic [31:0] mem_data;
    logic [31:0] gpio_out;
    logic        timer_irq;

    int          checks_cnt = 0;
    int          fail_cnt   = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    dmem_mmio dut (
        .clk       (clk),
        .rst       (rst),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .mem_sel   (mem_sel),
        .mem_data  (mem_data),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; a store ends just after the following negedge.
    task automatic bus_op(input string tag, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd);
        addr      = a;
        writedata = d;
        MemWrite  = we;
        exp_q.push_back(exp_rd);
        tag_q.push_back(tag);
        #1;
        check_eq(tag_q.pop_front(), readdata, exp_q.pop_front());
        if (we) begin
            @(negedge clk);
            MemWrite = 1'b0;
        end
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp_rd);
        bus_op(tag, 1'b0, a, 32'h0000_0000, exp_rd);
    endtask

    task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] pre_rd);
        bus_op(tag, 1'b1, a, d, pre_rd);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_dbg(input string tag, input logic [9:0] sel, input logic [31:0] exp);
        mem_sel = sel;
        #1;
        check_eq(tag, mem_data, exp);
    endtask

    initial begin
        rst       = 1'b1;
        MemWrite  = 1'b0;
        addr      = 32'h0000_0000;
        writedata = 32'h0000_0000;
        mem_sel   = 10'd0;
        idle(2);
        check_eq("rst_gpio", gpio_out, 32'h0000_0000);
        check_eq("rst_irq", {31'd0, timer_irq}, 32'h0000_0000);
        check_dbg("rst_ram", 10'd4, 32'h0000_0000);
        rst = 1'b0;

        load("cycle_rst", A_CYCLE, 32'd0);
`ifdef DMEM_MMIO_TIMER_EN
        load("tcmp_rst", A_TCMP, 32'hFFFF_FFFF);
        load("tcnt_rst", A_TCNT, 32'd0);
`endif
        idle(10);
        load("cycle10", A_CYCLE, 32'd10);
        store("cycle_st", A_CYCLE, 32'h0000_0055, 32'd10);
        load("cycle11", A_CYCLE, 32'd11);

        store("ram_st", 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
        load("ram_ld", 32'h0000_0010, 32'hDEAD_BEEF);
        load("ram_lsb", 32'h0000_0013, 32'hDEAD_BEEF);
        check_dbg("dbg4", 10'd4, 32'hDEAD_BEEF);
        store("ram_st2", 32'h0000_0014, 32'h0123_4567, 32'h0);
        store("no_bypass", 32'h0000_0014, 32'h89AB_CDEF, 32'h0123_4567);
        load("ram_ovw", 32'h0000_0014, 32'h89AB_CDEF);
        store("ram_top", 32'h0000_0FFC, 32'hA5A5_5A5A, 32'h0);
        load("ram_top_ld", 32'h0000_0FFC, 32'hA5A5_5A5A);
        check_dbg("dbg1023", 10'd1023, 32'hA5A5_5A5A);

        load("unmap_ld", 32'h0000_1000, 32'h0);
        store("unmap_st0", 32'h0000_1000, 32'h1111_1111, 32'h0);
        store("unmap_st4", 32'h0000_1010, 32'h2222_2222, 32'h0);
        store("unmap_near", 32'hFFFE_0004, 32'h3333_3333, 32'h0);
        load("alias0", 32'h0000_0000, 32'h0);
        load("alias4", 32'h0000_0010, 32'hDEAD_BEEF);
        check_dbg("dbg0", 10'd0, 32'h0);

        store("gpio_st", A_GPIO, 32'hCAFE_F00D, 32'h0);
        check_eq("gpio_out", gpio_out, 32'hCAFE_F00D);
        load("gpio_ld", A_GPIO, 32'hCAFE_F00D);
        load("off14", 32'hFFFF_0014, 32'h0);
        load("page_miss", 32'hFFFF_0104, 32'h0);

`ifdef DMEM_MMIO_TIMER_EN
        store("tcmp_st", A_TCMP, 32'd3, 32'hFFFF_FFFF);
        store("tctrl_st", A_TCTRL, 32'h0000_000B, 32'h0);
        load("tcnt0", A_TCNT, 32'd0);
        idle(1);
        load("tcnt1", A_TCNT, 32'd1);
        idle(1);
        load("tcnt2", A_TCNT, 32'd2);
        idle(1);
        load("tcnt3", A_TCNT, 32'd3);
        check_eq("irq_pre", {31'd0, timer_irq}, 32'd0);
        idle(1);
        load("tcnt_rl", A_TCNT, 32'd0);
        check_eq("irq_match", {31'd0, timer_irq}, 32'd1);
        load("tctrl_m", A_TCTRL, 32'h0000_000F);
        idle(3);
        load("tcnt3b", A_TCNT, 32'd3);
        store("w1c_race", A_TCTRL, 32'h0000_000F, 32'h0000_000F);
        load("tctrl_keep", A_TCTRL, 32'h0000_000F);
        check_eq("irq_keep", {31'd0, timer_irq}, 32'd1);
        store("w1c", A_TCTRL, 32'h0000_000F, 32'h0000_000F);
        load("tctrl_clr", A_TCTRL, 32'h0000_000B);
        check_eq("irq_clr", {31'd0, timer_irq}, 32'd0);
        store("tcnt_wr", A_TCNT, 32'h0000_0100, 32'd1);
        load("tcnt_100", A_TCNT, 32'h0000_0100);
        idle(1);
        load("tcnt_101", A_TCNT, 32'h0000_0101);
        store("tctrl_off", A_TCTRL, 32'h0, 32'h0000_000B);
        idle(3);
        load("tcnt_hold", A_TCNT, 32'h0000_0102);
`else
        store("ntm_tctrl", A_TCTRL, 32'h0000_000B, 32'h0);
        store("ntm_tcmp", A_TCMP, 32'h0, 32'h0);
        store("ntm_tcnt", A_TCNT, 32'd5, 32'h0);
        idle(4);
        load("ntm_tcnt_ld", A_TCNT, 32'h0);
        load("ntm_tcmp_ld", A_TCMP, 32'h0);
        load("ntm_tctrl_ld", A_TCTRL, 32'h0);
        check_eq("ntm_irq", {31'd0, timer_irq}, 32'd0);
`endif

        addr      = A_GPIO;
        writedata = 32'h0000_0055;
        MemWrite  = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async", gpio_out, 32'h0);
        @(negedge clk);
        MemWrite = 1'b0;
        rst      = 1'b0;
        check_eq("rst_gpio2", gpio_out, 32'h0);
        load("rst_gpio_ld", A_GPIO, 32'h0);
        load("rst_cycle", A_CYCLE, 32'h0);
        check_dbg("rst_ram4", 10'd4, 32'h0);
`ifdef DMEM_MMIO_TIMER_EN
        load("rst_tcnt", A_TCNT, 32'h0);
        load("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
        load("rst_tctrl", A_TCTRL, 32'h0);
`else
        load("rst_off08", A_TCNT, 32'h0);
`endif
        check_eq("rst_irq2", {31'd0, timer_irq}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
